// File: rtl/key_db_pkg.sv
// Shared types and sizing helpers for the key debounce bank.
package key_db_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_DB,
    HELD,
    RELEASE_DB
  } key_state_t;

  localparam int unsigned DEF_N_KEYS        = 6;
  localparam int unsigned DEF_DB_CYCLES     = 1_000_000;
  localparam int unsigned DEF_LONG_CYCLES   = 50_000_000;
  localparam int unsigned DEF_REPEAT_CYCLES = 10_000_000;

  // Counter is shared by all phases, so it is sized for the longest terminal count.
  function automatic int unsigned cnt_width(input int unsigned long_c,
                                            input int unsigned db_c,
                                            input int unsigned rep_c);
    int unsigned m;
    m = long_c;
    if (db_c > m) m = db_c;
    if (rep_c > m) m = rep_c;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/key_debounce_cell.sv
// One key: 2-FF synchroniser, debounce FSM and shared phase counter.
module key_debounce_cell
  import key_db_pkg::*;
#(
  parameter int unsigned DB_CYCLES     = DEF_DB_CYCLES,
  parameter int unsigned LONG_CYCLES   = DEF_LONG_CYCLES,
  parameter int unsigned REPEAT_CYCLES = DEF_REPEAT_CYCLES
) (
  input  logic clk_50M,
  input  logic rst,
  input  logic key_n,
  output logic level,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_pulse,
  output logic repeat_pulse
);

  localparam int unsigned CW = cnt_width(LONG_CYCLES, DB_CYCLES, REPEAT_CYCLES);
  localparam logic [CW-1:0] DB_LAST     = CW'(DB_CYCLES - 1);
  localparam logic [CW-1:0] LONG_LAST   = CW'(LONG_CYCLES - 1);
  localparam logic [CW-1:0] REPEAT_LAST = CW'(REPEAT_CYCLES - 1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  key_state_t    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          long_done_q, long_done_d;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic          release_q, release_d;
  logic          long_q, long_d;
  logic          repeat_q, repeat_d;
  logic          s;

  assign s = sync2_q;

  always_ff @(posedge clk_50M) begin
    if (rst) begin
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      state_q     <= IDLE;
      cnt_q       <= '0;
      long_done_q <= 1'b0;
      level_q     <= 1'b0;
      press_q     <= 1'b0;
      release_q   <= 1'b0;
      long_q      <= 1'b0;
      repeat_q    <= 1'b0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      long_done_q <= long_done_d;
      level_q     <= level_d;
      press_q     <= press_d;
      release_q   <= release_d;
      long_q      <= long_d;
      repeat_q    <= repeat_d;
    end
  end

  always_comb begin
    sync1_d     = key_n;
    sync2_d     = sync1_q;
    state_d     = state_q;
    cnt_d       = cnt_q;
    long_done_d = long_done_q;
    level_d     = level_q;
    press_d     = 1'b0;
    release_d   = 1'b0;
    long_d      = 1'b0;
    repeat_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!s) begin
          state_d = PRESS_DB;
          cnt_d   = '0;
        end
      end
      PRESS_DB: begin
        if (s) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == DB_LAST) begin
          state_d = HELD;
          cnt_d   = '0;
          level_d = 1'b1;
          press_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HELD: begin
        if (s) begin
          state_d = RELEASE_DB;
          cnt_d   = '0;
        end else if (!long_done_q) begin
          if (cnt_q == LONG_LAST) begin
            long_d      = 1'b1;
            long_done_d = 1'b1;
            cnt_d       = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else begin
          if (cnt_q == REPEAT_LAST) begin
            repeat_d = 1'b1;
            cnt_d    = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      RELEASE_DB: begin
        // A bounce back to pressed keeps long_done; hold/repeat timing restarts.
        if (!s) begin
          state_d = HELD;
          cnt_d   = '0;
        end else if (cnt_q == DB_LAST) begin
          state_d     = IDLE;
          cnt_d       = '0;
          level_d     = 1'b0;
          release_d   = 1'b1;
          long_done_d = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign level         = level_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign long_pulse    = long_q;
  assign repeat_pulse  = repeat_q;

endmodule

// File: rtl/key_debounce_bank.sv
// Bank of independent key debounce cells feeding the timer core.
module key_debounce_bank
  import key_db_pkg::*;
#(
  parameter int unsigned N_KEYS        = DEF_N_KEYS,
  parameter int unsigned DB_CYCLES     = DEF_DB_CYCLES,
  parameter int unsigned LONG_CYCLES   = DEF_LONG_CYCLES,
  parameter int unsigned REPEAT_CYCLES = DEF_REPEAT_CYCLES
) (
  input  logic              clk_50M,
  input  logic              rst,
  input  logic [N_KEYS-1:0] key_n,
  output logic [N_KEYS-1:0] level,
  output logic [N_KEYS-1:0] press_pulse,
  output logic [N_KEYS-1:0] release_pulse,
  output logic [N_KEYS-1:0] long_pulse,
  output logic [N_KEYS-1:0] repeat_pulse,
  output logic              any_level
);

  for (genvar i = 0; i < N_KEYS; i++) begin : g_key
    key_debounce_cell #(
      .DB_CYCLES     (DB_CYCLES),
      .LONG_CYCLES   (LONG_CYCLES),
      .REPEAT_CYCLES (REPEAT_CYCLES)
    ) u_cell (
      .clk_50M       (clk_50M),
      .rst           (rst),
      .key_n         (key_n[i]),
      .level         (level[i]),
      .press_pulse   (press_pulse[i]),
      .release_pulse (release_pulse[i]),
      .long_pulse    (long_pulse[i]),
      .repeat_pulse  (repeat_pulse[i])
    );
  end

  assign any_level = |level;

endmodule

// File: tb/tb_key_debounce_bank.sv
// Directed bench for key_debounce_bank with short debounce/hold/repeat windows.
module tb_key_debounce_bank;

  localparam int unsigned N  = 6;
  localparam int unsigned DB = 4;
  localparam int unsigned LG = 20;
  localparam int unsigned RP = 5;

  logic         clk_50M;
  logic         rst;
  logic [N-1:0] key_n;
  logic [N-1:0] level, press_pulse, release_pulse, long_pulse, repeat_pulse;
  logic         any_level;
  logic [30:0]  obs;

  int n_vec;
  int n_err;

  key_debounce_bank #(
    .N_KEYS        (N),
    .DB_CYCLES     (DB),
    .LONG_CYCLES   (LG),
    .REPEAT_CYCLES (RP)
  ) dut (
    .clk_50M       (clk_50M),
    .rst           (rst),
    .key_n         (key_n),
    .level         (level),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse),
    .long_pulse    (long_pulse),
    .repeat_pulse  (repeat_pulse),
    .any_level     (any_level)
  );

  assign obs = {level, press_pulse, release_pulse, long_pulse, repeat_pulse, any_level};

  initial clk_50M = 1'b0;
  always #5 clk_50M = ~clk_50M;

  task automatic step();
    @(posedge clk_50M);
    #1;
  endtask

  // Leaves reset deasserted with all keys released; next edge is local edge 1.
  task automatic apply_reset();
    rst   = 1'b1;
    key_n = '1;
    repeat (3) step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    key_n = '1;
    for (int k = 1; k <= 3; k++) begin
      step();
      n_vec++;
      if (obs !== 31'd0) begin
        n_err++;
        $display("FAIL reset k=%0d got=%b exp=%b", k, obs, 31'd0);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_clean_press();
    logic [N-1:0] e_l, e_p, e_r, e_g, e_t;
    apply_reset();
    key_n[0] = 1'b0;
    for (int k = 1; k <= 25; k++) begin
      step();
      e_l = (k >= 7 && k < 19) ? 6'b000001 : 6'b0;
      e_p = (k == 7)  ? 6'b000001 : 6'b0;
      e_r = (k == 19) ? 6'b000001 : 6'b0;
      e_g = '0;
      e_t = '0;
      n_vec++;
      if (obs !== {e_l, e_p, e_r, e_g, e_t, |e_l}) begin
        n_err++;
        $display("FAIL clean_press k=%0d got=%b exp=%b", k, obs, {e_l, e_p, e_r, e_g, e_t, |e_l});
      end
      if (k == 12) key_n[0] = 1'b1;
    end
  endtask

  task automatic test_bounce_reject();
    apply_reset();
    key_n[1] = 1'b0;
    for (int k = 1; k <= 15; k++) begin
      step();
      n_vec++;
      if (obs !== 31'd0) begin
        n_err++;
        $display("FAIL bounce_reject k=%0d got=%b exp=%b", k, obs, 31'd0);
      end
      if (k == 2) key_n[1] = 1'b1;
      if (k == 3) key_n[1] = 1'b0;
      if (k == 5) key_n[1] = 1'b1;
    end
  endtask

  task automatic test_long_repeat();
    logic [N-1:0] e_l, e_p, e_r, e_g, e_t;
    apply_reset();
    key_n[2] = 1'b0;
    for (int k = 1; k <= 65; k++) begin
      step();
      e_l = (k >= 7 && k < 57) ? 6'b000100 : 6'b0;
      e_p = (k == 7)  ? 6'b000100 : 6'b0;
      e_r = (k == 57) ? 6'b000100 : 6'b0;
      e_g = (k == 27) ? 6'b000100 : 6'b0;
      e_t = (k == 32 || k == 37 || k == 42 || k == 47 || k == 52) ? 6'b000100 : 6'b0;
      n_vec++;
      if (obs !== {e_l, e_p, e_r, e_g, e_t, |e_l}) begin
        n_err++;
        $display("FAIL long_repeat k=%0d got=%b exp=%b", k, obs, {e_l, e_p, e_r, e_g, e_t, |e_l});
      end
      if (k == 50) key_n[2] = 1'b1;
    end
  endtask

  task automatic test_release_bounce();
    logic [N-1:0] e_l, e_p, e_r, e_g, e_t;
    apply_reset();
    key_n[3] = 1'b0;
    for (int k = 1; k <= 52; k++) begin
      step();
      e_l = (k >= 7 && k < 47) ? 6'b001000 : 6'b0;
      e_p = (k == 7)  ? 6'b001000 : 6'b0;
      e_r = (k == 47) ? 6'b001000 : 6'b0;
      e_g = (k == 34) ? 6'b001000 : 6'b0;
      e_t = (k == 39) ? 6'b001000 : 6'b0;
      n_vec++;
      if (obs !== {e_l, e_p, e_r, e_g, e_t, |e_l}) begin
        n_err++;
        $display("FAIL release_bounce k=%0d got=%b exp=%b", k, obs, {e_l, e_p, e_r, e_g, e_t, |e_l});
      end
      if (k == 9)  key_n[3] = 1'b1;
      if (k == 11) key_n[3] = 1'b0;
      if (k == 40) key_n[3] = 1'b1;
    end
  endtask

  task automatic test_reset_mid_debounce();
    logic [N-1:0] e_l, e_p, e_r, e_g, e_t;
    apply_reset();
    key_n[4] = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      step();
      e_l = (k >= 15 && k < 27) ? 6'b010000 : 6'b0;
      e_p = (k == 15) ? 6'b010000 : 6'b0;
      e_r = (k == 27) ? 6'b010000 : 6'b0;
      e_g = '0;
      e_t = '0;
      n_vec++;
      if (obs !== {e_l, e_p, e_r, e_g, e_t, |e_l}) begin
        n_err++;
        $display("FAIL reset_mid k=%0d got=%b exp=%b", k, obs, {e_l, e_p, e_r, e_g, e_t, |e_l});
      end
      if (k == 5)  rst = 1'b1;
      if (k == 8)  rst = 1'b0;
      if (k == 20) key_n[4] = 1'b1;
    end
  endtask

  task automatic test_back_to_back();
    logic [N-1:0] e_l, e_p, e_r, e_g, e_t;
    apply_reset();
    key_n[0] = 1'b0;
    key_n[5] = 1'b0;
    for (int k = 1; k <= 26; k++) begin
      step();
      e_l = '0;
      if (k >= 7 && k < 17) e_l[0] = 1'b1;
      if (k >= 7 && k < 21) e_l[5] = 1'b1;
      e_p = (k == 7) ? 6'b100001 : 6'b0;
      e_r = (k == 17) ? 6'b000001 : (k == 21) ? 6'b100000 : 6'b0;
      e_g = '0;
      e_t = '0;
      n_vec++;
      if (obs !== {e_l, e_p, e_r, e_g, e_t, |e_l}) begin
        n_err++;
        $display("FAIL simultaneous k=%0d got=%b exp=%b", k, obs, {e_l, e_p, e_r, e_g, e_t, |e_l});
      end
      if (k == 10) key_n[0] = 1'b1;
      if (k == 14) key_n[5] = 1'b1;
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst   = 1'b1;
    key_n = '1;
    test_reset();
    test_clean_press();
    test_bounce_reject();
    test_long_repeat();
    test_release_bounce();
    test_reset_mid_debounce();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
